// File: rtl/alu_16.sv
// rtl/alu_16.sv - 16-bit registered ALU (13 ops, N/Z/C flags); optional V flag under ALU16_OVF_EN
module alu_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] R,
  input  logic [15:0] S,
  input  logic [3:0]  Alu_Op,
  output logic [15:0] Y,
  output logic        N,
  output logic        Z,
  output logic        C
`ifdef ALU16_OVF_EN
  ,
  output logic        V
`endif
);

  localparam logic [3:0] OP_PASS_S = 4'h0;
  localparam logic [3:0] OP_PASS_R = 4'h1;
  localparam logic [3:0] OP_INC    = 4'h2;
  localparam logic [3:0] OP_DEC    = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_SUB    = 4'h5;
  localparam logic [3:0] OP_SHR    = 4'h6;
  localparam logic [3:0] OP_SHL    = 4'h7;
  localparam logic [3:0] OP_AND    = 4'h8;
  localparam logic [3:0] OP_OR     = 4'h9;
  localparam logic [3:0] OP_XOR    = 4'hA;
  localparam logic [3:0] OP_NOT    = 4'hB;
  localparam logic [3:0] OP_NEG    = 4'hC;

  // 17-bit arithmetic: bit 16 is the carry out (add) or the borrow (subtract)
  logic [16:0] sum_add, sum_sub, sum_inc, sum_dec, sum_neg;
  assign sum_add = {1'b0, R} + {1'b0, S};
  assign sum_sub = {1'b0, R} - {1'b0, S};
  assign sum_inc = {1'b0, S} + 17'd1;
  assign sum_dec = {1'b0, S} - 17'd1;
  assign sum_neg = 17'd0 - {1'b0, S};

  logic [15:0] y_d, y_q;
  logic        c_d, c_q;
  logic        n_q, z_q;

  // Next result and carry; reserved opcodes fall through to zero
  always_comb begin
    y_d = 16'h0000;
    c_d = 1'b0;
    case (Alu_Op)
      OP_PASS_S: y_d = S;
      OP_PASS_R: y_d = R;
      OP_INC:    {c_d, y_d} = sum_inc;
      OP_DEC:    {c_d, y_d} = sum_dec;
      OP_ADD:    {c_d, y_d} = sum_add;
      OP_SUB:    {c_d, y_d} = sum_sub;
      OP_SHR:    begin y_d = {1'b0, S[15:1]}; c_d = S[0];  end
      OP_SHL:    begin y_d = {S[14:0], 1'b0}; c_d = S[15]; end
      OP_AND:    y_d = R & S;
      OP_OR:     y_d = R | S;
      OP_XOR:    y_d = R ^ S;
      OP_NOT:    y_d = ~S;
      OP_NEG:    {c_d, y_d} = sum_neg;
      default:   y_d = 16'h0000;
    endcase
  end

  // Result and flag register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= 16'h0000;
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      y_q <= y_d;
      n_q <= y_d[15];
      z_q <= (y_d == 16'h0000);
      c_q <= c_d;
    end
  end

  assign Y = y_q;
  assign N = n_q;
  assign Z = z_q;
  assign C = c_q;

`ifdef ALU16_OVF_EN
  logic v_d, v_q;

  // Signed overflow: result sign disagrees with what the operand signs allow
  always_comb begin
    v_d = 1'b0;
    case (Alu_Op)
      OP_INC: v_d = ~S[15] & sum_inc[15];
      OP_DEC: v_d = S[15] & ~sum_dec[15];
      OP_ADD: v_d = (R[15] == S[15]) && (sum_add[15] != R[15]);
      OP_SUB: v_d = (R[15] != S[15]) && (sum_sub[15] != R[15]);
      OP_NEG: v_d = S[15] & sum_neg[15];
      default: v_d = 1'b0;
    endcase
  end

  // Overflow flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  assign V = v_q;
`endif

endmodule

// File: tb/tb_alu_16.sv
// tb/tb_alu_16.sv - scoreboard testbench for alu_16
module tb_alu_16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] R, S;
  logic [3:0]  Alu_Op;
  logic [15:0] Y;
  logic        N, Z, C;
  logic        obs_v;

`ifdef ALU16_OVF_EN
  logic V;
  assign obs_v = V;
`else
  assign obs_v = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_16 dut (
    .clk(clk), .reset(reset), .R(R), .S(S), .Alu_Op(Alu_Op),
    .Y(Y), .N(N), .Z(Z), .C(C)
`ifdef ALU16_OVF_EN
    , .V(V)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] y;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] r;
    logic [15:0] s;
    logic [15:0] y;
    logic        c;
    logic        v;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string name, logic [3:0] op, logic [15:0] r, logic [15:0] s,
                              logic [15:0] y, logic c, logic v);
    vec_t t;
    t.name = name; t.op = op; t.r = r; t.s = s; t.y = y; t.c = c; t.v = v;
    return t;
  endfunction

  function automatic logic ovf_on();
`ifdef ALU16_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model working in integer arithmetic
  function automatic exp_t model(logic [3:0] op, logic [15:0] r, logic [15:0] s);
    exp_t        e;
    int unsigned ru = r;
    int unsigned su = s;
    int          ri = $signed(r);
    int          si = $signed(s);
    int          d;
    e.name = "b2b"; e.y = 16'h0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      4'h0: e.y = s;
      4'h1: e.y = r;
      4'h2: begin e.y = 16'(su + 1); e.c = (su + 1) > 32'hFFFF; d = si + 1; e.v = d > 32767; end
      4'h3: begin e.y = 16'(su - 1); e.c = (su == 0); d = si - 1; e.v = d < -32768; end
      4'h4: begin e.y = 16'(ru + su); e.c = (ru + su) > 32'hFFFF; d = ri + si; e.v = (d > 32767) || (d < -32768); end
      4'h5: begin e.y = 16'(ru - su); e.c = (ru < su); d = ri - si; e.v = (d > 32767) || (d < -32768); end
      4'h6: begin e.y = 16'(su / 2); e.c = s[0]; end
      4'h7: begin e.y = 16'(su * 2); e.c = (su >= 32'h8000); end
      4'h8: e.y = r & s;
      4'h9: e.y = r | s;
      4'hA: e.y = r ^ s;
      4'hB: e.y = 16'(32'hFFFF - su);
      4'hC: begin e.y = 16'(32'h10000 - su); e.c = (su != 0); d = 0 - si; e.v = d > 32767; end
      default: e.y = 16'h0;
    endcase
    if (!ovf_on()) e.v = 1'b0;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; Alu_Op = 4'h0; R = 16'h0000; S = 16'h55AA;
    #2;
    vectors++;
    if ({Y, N, Z, C, obs_v} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_async: got Y=%h N=%b Z=%b C=%b V=%b, want all 0", Y, N, Z, C, obs_v);
    end
    @(posedge clk); #1;
    vectors++;
    if ({Y, N, Z, C, obs_v} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got Y=%h N=%b Z=%b C=%b V=%b, want all 0", Y, N, Z, C, obs_v);
    end
    @(negedge clk);
    reset = 1'b0;
    e.name = "op0_after_reset"; e.y = 16'h55AA; e.c = 1'b0; e.v = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({Y, N, Z, C, obs_v} !== {e.y, e.y[15], e.y == 16'h0, e.c, e.v}) begin
      miscompares++;
      $display("FAIL %s: got Y=%h N=%b Z=%b C=%b V=%b, want Y=%h C=%b V=%b",
               e.name, Y, N, Z, C, obs_v, e.y, e.c, e.v);
    end
  endtask

  task automatic test_arith();
    vec_t tbl[7];
    exp_t e;
    tbl[0] = mk("add",     4'h4, 16'hD2D2, 16'h2D2D, 16'hFFFF, 1'b0, 1'b0);
    tbl[1] = mk("sub",     4'h5, 16'hE1E1, 16'h1E1E, 16'hC3C3, 1'b0, 1'b0);
    tbl[2] = mk("neg",     4'hC, 16'h0000, 16'hDCBA, 16'h2346, 1'b1, 1'b0);
    tbl[3] = mk("inc_wrap",4'h2, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    tbl[4] = mk("dec_wrap",4'h3, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    tbl[5] = mk("inc",     4'h2, 16'h0000, 16'h3C3C, 16'h3C3D, 1'b0, 1'b0);
    tbl[6] = mk("sub_brw", 4'h5, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
    foreach (tbl[i]) begin
      @(negedge clk);
      Alu_Op = tbl[i].op; R = tbl[i].r; S = tbl[i].s;
      e.name = tbl[i].name; e.y = tbl[i].y; e.c = tbl[i].c; e.v = tbl[i].v & ovf_on();
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({Y, N, Z, C, obs_v} !== {e.y, e.y[15], e.y == 16'h0, e.c, e.v}) begin
        miscompares++;
        $display("FAIL %s: got Y=%h N=%b Z=%b C=%b V=%b, want Y=%h C=%b V=%b",
                 e.name, Y, N, Z, C, obs_v, e.y, e.c, e.v);
      end
    end
  endtask

  task automatic test_shift_logic();
    vec_t tbl[9];
    exp_t e;
    tbl[0] = mk("shr",    4'h6, 16'h0000, 16'h0F0F, 16'h0787, 1'b1, 1'b0);
    tbl[1] = mk("shl",    4'h7, 16'h0000, 16'hEEEE, 16'hDDDC, 1'b1, 1'b0);
    tbl[2] = mk("and",    4'h8, 16'hBBBB, 16'h4444, 16'h0000, 1'b0, 1'b0);
    tbl[3] = mk("or",     4'h9, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);
    tbl[4] = mk("xor",    4'hA, 16'h4040, 16'h0404, 16'h4444, 1'b0, 1'b0);
    tbl[5] = mk("not",    4'hB, 16'h0000, 16'hEFEF, 16'h1010, 1'b0, 1'b0);
    tbl[6] = mk("rsvd_e", 4'hE, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0);
    tbl[7] = mk("pass_r", 4'h1, 16'h9876, 16'h1111, 16'h9876, 1'b0, 1'b0);
    tbl[8] = mk("rsvd_f", 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      @(negedge clk);
      Alu_Op = tbl[i].op; R = tbl[i].r; S = tbl[i].s;
      e.name = tbl[i].name; e.y = tbl[i].y; e.c = tbl[i].c; e.v = tbl[i].v & ovf_on();
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({Y, N, Z, C, obs_v} !== {e.y, e.y[15], e.y == 16'h0, e.c, e.v}) begin
        miscompares++;
        $display("FAIL %s: got Y=%h N=%b Z=%b C=%b V=%b, want Y=%h C=%b V=%b",
                 e.name, Y, N, Z, C, obs_v, e.y, e.c, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0]  op;
    logic [15:0] r, s;
    for (int i = 0; i < 60; i++) begin
      op = 4'(i % 16);
      r  = 16'($urandom);
      s  = (i % 7 == 0) ? 16'h8000 : (i % 11 == 0) ? 16'h7FFF : 16'($urandom);
      @(negedge clk);
      Alu_Op = op; R = r; S = s;
      sb.push_back(model(op, r, s));
      @(posedge clk); #1;
      if (sb.size() != 1) begin
        vectors++; miscompares++;
        $display("FAIL b2b_queue: got depth %0d, want 1", sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        vectors++;
        if ({Y, N, Z, C, obs_v} !== {e.y, e.y[15], e.y == 16'h0, e.c, e.v}) begin
          miscompares++;
          $display("FAIL b2b op=%h R=%h S=%h: got Y=%h N=%b Z=%b C=%b V=%b, want Y=%h C=%b V=%b",
                   op, r, s, Y, N, Z, C, obs_v, e.y, e.c, e.v);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    @(negedge clk);
    Alu_Op = 4'h3; R = 16'h0000; S = 16'h0000;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({Y, N, Z, C, obs_v} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got Y=%h N=%b Z=%b C=%b V=%b, want all 0", Y, N, Z, C, obs_v);
    end
    Alu_Op = 4'h1; R = 16'h1234;
    @(negedge clk);
    reset = 1'b0;
    e.name = "first_after_mid_reset"; e.y = 16'h1234; e.c = 1'b0; e.v = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({Y, N, Z, C, obs_v} !== {e.y, e.y[15], e.y == 16'h0, e.c, e.v}) begin
      miscompares++;
      $display("FAIL %s: got Y=%h N=%b Z=%b C=%b V=%b, want Y=%h C=%b V=%b",
               e.name, Y, N, Z, C, obs_v, e.y, e.c, e.v);
    end
  endtask

  task automatic test_overflow();
    vec_t tbl[4];
    exp_t e;
    tbl[0] = mk("ovf_add", 4'h4, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    tbl[1] = mk("ovf_neg", 4'hC, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1);
    tbl[2] = mk("ovf_sub", 4'h5, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    tbl[3] = mk("ovf_inc", 4'h2, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
    foreach (tbl[i]) begin
      @(negedge clk);
      Alu_Op = tbl[i].op; R = tbl[i].r; S = tbl[i].s;
      e.name = tbl[i].name; e.y = tbl[i].y; e.c = tbl[i].c; e.v = tbl[i].v & ovf_on();
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({Y, N, Z, C, obs_v} !== {e.y, e.y[15], e.y == 16'h0, e.c, e.v}) begin
        miscompares++;
        $display("FAIL %s: got Y=%h N=%b Z=%b C=%b V=%b, want Y=%h C=%b V=%b",
                 e.name, Y, N, Z, C, obs_v, e.y, e.c, e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_shift_logic();
    test_back_to_back();
    test_reset_midstream();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
